multicycle_main_ctrl: RTL

//  Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/main_ctrl_outdec.sv | 56 +++++
 rtl/multicycle_main_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcode, ALUOp, state and control-word definitions for the MIPS control path
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd12;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/main_ctrl_outdec.sv
// rtl/main_ctrl_outdec.sv - combinational state to control-word decoder (JUMP gated by MULTICYCLE_MAIN_CTRL_JUMP_EN)
module main_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
            end
            S_DECODE: ctrl_o.alu_src_b = SRCB_IMMSH2;
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: ctrl_o.iord = 1'b1;
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_ALUWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_ADDIWB: ctrl_o.reg_write = 1'b1;
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                ctrl_o.branch    = 1'b1;
            end
`ifdef MULTICYCLE_MAIN_CTRL_JUMP_EN
            S_JUMP: begin
                ctrl_o.pc_src   = PCSRC_JUMP;
                ctrl_o.pc_write = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// rtl/multicycle_main_ctrl.sv - multicycle MIPS main control FSM; j decode enabled by MULTICYCLE_MAIN_CTRL_JUMP_EN
module multicycle_main_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W      = 4,
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSrc,
    output logic               PCWrite,
    output logic               Branch,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       op_known;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        op_known = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: op_known = 1'b1;
`ifdef MULTICYCLE_MAIN_CTRL_JUMP_EN
            OP_J:                                     op_known = 1'b1;
`endif
            default:                                  op_known = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef MULTICYCLE_MAIN_CTRL_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            // op is still the IR contents here because IRWrite is low outside FETCH
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    main_ctrl_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // Write enables are killed while reset is high so the reset cycle commits nothing
    always_comb begin
        IorD      = ctrl.iord;
        MemWrite  = ctrl.mem_write & ~reset;
        IRWrite   = ctrl.ir_write & ~reset;
        RegDst    = ctrl.reg_dst;
        MemtoReg  = ctrl.mem_to_reg;
        RegWrite  = ctrl.reg_write & ~reset;
        ALUSrcA   = ctrl.alu_src_a;
        ALUSrcB   = ctrl.alu_src_b;
        ALUOp     = ctrl.alu_op;
        PCSrc     = ctrl.pc_src;
        PCWrite   = ctrl.pc_write & ~reset;
        Branch    = ctrl.branch & ~reset;
        illegal   = (state_q == S_DECODE) & ~op_known & ~reset;
        dbg_state = STATE_W'(state_q);
    end

endmodule
